apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Shares the single APB master among NUM_REQ requesters (CPU port, DMA, debug, ...).
//  Round-robin arbitration; grants one request, drives the master's transfer/command inputs,
//  waits for slave completion or timeout, returns read data/status to the granted requester.
//  Sits between the requesters and APB_MASTER in the APB top; the scan clock/reset muxes stay upstream.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  AW           8    address width
//  DW           8    data width
//  TIMEOUT      16   max WAIT cycles before error response; 0 = timeout disabled
// PORTS
//  PCLK           in   1          clock
//  PRESETn        in   1          async active-low reset
//  arb_en         in   1          1 = arbitration enabled; 0 = no new grants (current transfer completes)
//  req_valid      in   NUM_REQ    per-requester request
//  req_write      in   NUM_REQ    1 = write, 0 = read
//  req_addr       in   NUM_REQ*AW packed addresses, requester i at [i*AW +: AW]
//  req_wdata      in   NUM_REQ*DW packed write data
//  req_ready      out  NUM_REQ    one-hot 1-cycle pulse: request captured
//  rsp_valid      out  NUM_REQ    one-hot 1-cycle pulse: response available
//  rsp_rdata      out  DW         read data (0 for writes and errors)
//  rsp_err        out  1          timeout error flag, qualified by rsp_valid
//  busy           out  1          1 whenever state != IDLE
//  m_transfer     out  1          to master transfer
//  m_read_write   out  1          to master READ_WRITE: 1 = read, 0 = write
//  m_write_paddr  out  AW         to master write address
//  m_write_data   out  DW         to master write data
//  m_read_paddr   out  AW         to master read address
//  m_penable      in   1          master PENABLE
//  m_pready       in   1          slave PREADY
//  m_read_data    in   DW         master read data out
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_grant = NUM_REQ-1 (requester 0 wins first); timer 0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, all outputs registered.
//  IDLE: if arb_en && |req_valid: pick first valid index searching from last_grant+1 with
//   wrap-around; latch grant, write, addr, wdata; pulse req_ready[g]; -> ISSUE. Else stay.
//  ISSUE: m_transfer=1; m_read_write=~write; write: m_write_paddr=addr, m_write_data=wdata,
//   read: m_read_paddr=addr; unused address/data outputs held 0; timer cleared; -> WAIT.
//  WAIT: m_transfer and command fields held stable. On m_penable && m_pready: capture
//   m_read_data (reads) -> RESP, err=0. Else timer++; if TIMEOUT!=0 and timer reaches
//   TIMEOUT-1 with no completion -> RESP, err=1, rdata=0. Completion in the same cycle
//   as timeout expiry wins (err=0).
//  RESP: m_transfer=0 and command fields 0; rsp_valid[g]=1 one cycle with rsp_rdata/rsp_err;
//   last_grant=g; -> IDLE. m_transfer is low >=2 cycles between transfers.
//  Latency: req_valid seen in IDLE -> m_transfer high 1 cycle later; completion -> rsp_valid
//   1 cycle later. Min 4 cycles per transfer with zero-wait slave.
//  req_valid deasserted after req_ready: no effect, request already owned. Deasserted before
//   capture: never granted. New requests during non-IDLE states wait; no queueing.
//  arb_en falling mid-transfer: transfer completes normally; no grant while low.
//  rsp_rdata/rsp_err hold last value between responses; rsp_valid is the only qualifier.
//  Timer width $clog2(TIMEOUT+1) (min 1); saturates, never wraps.
//  PRESETn asserted mid-transfer: immediate return to reset values, in-flight request dropped,
//   no response pulse.
// STRUCTURE
//  apb_arb_pkg: state enum {IDLE, ISSUE, WAIT, RESP}, READ/WRITE encoding localparams.
//  Sub-module rr_arbiter #(NUM_REQ): combinational, inputs req, last_grant; outputs grant
//   index + any_req. FSM, latches and timer in apb_req_arbiter.
// TESTING
//  Reset, req_valid=0 -> all outputs 0, busy=0, m_transfer never rises.
//  Req0 write addr 0x12 data 0xA5, zero-wait slave -> req_ready[0] next cycle, m_transfer with
//   m_read_write=0, rsp_valid[0] pulse, rsp_err=0, rsp_rdata=0.
//  Req2 read addr 0x34, slave returns 0x5C after 3 wait cycles -> rsp_valid[2], rsp_rdata=0x5C.
//  req_valid=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3, no starvation.
//  TIMEOUT=16, m_pready stuck 0 -> rsp_err=1, rsp_rdata=0 after 16 WAIT cycles; next req served.
//  PRESETn low during WAIT -> outputs 0 immediately; after release requester 0 served first.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB requester arbiter: FSM state encoding, the
// READ_WRITE command encoding and the timeout timer sizing rule.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Timer must be able to count up to TIMEOUT; keep at least one bit when timeout is disabled
  function automatic int timer_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward
// from last_grant+1 with wrap-around.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      grant,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rotated;
  int                 offset;
  int                 idx;

  // Rotate so bit 0 is the requester right after last_grant; lowest set bit wins
  always_comb begin
    rotated = NUM_REQ'({req, req} >> (int'(last_grant) + 1));
    offset  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) offset = k;
    end
    any_req = |req;
    idx     = int'(last_grant) + 1 + offset;
    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
    grant   = GW'(idx);
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master among NUM_REQ requesters with round-robin grants,
// per-transfer timeout and registered request/response handshakes.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  arb_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  m_transfer,
  output logic                  m_read_write,
  output logic [AW-1:0]         m_write_paddr,
  output logic [DW-1:0]         m_write_data,
  output logic [AW-1:0]         m_read_paddr,
  input  logic                  m_penable,
  input  logic                  m_pready,
  input  logic [DW-1:0]         m_read_data
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0]      TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

  arb_state_e state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_grant_q, last_grant_d, arb_grant;
  logic          write_q, write_d, arb_any;
  logic [TW-1:0] timer_q, timer_d;

  logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_d, m_write_data_d;
  logic               rsp_err_d, busy_d, m_transfer_d, m_read_write_d;
  logic [AW-1:0]      m_write_paddr_d, m_read_paddr_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    write_d         = write_q;
    timer_d         = timer_q;
    req_ready_d     = '0;
    rsp_valid_d     = '0;
    rsp_rdata_d     = rsp_rdata;
    rsp_err_d       = rsp_err;
    m_transfer_d    = m_transfer;
    m_read_write_d  = m_read_write;
    m_write_paddr_d = m_write_paddr;
    m_write_data_d  = m_write_data;
    m_read_paddr_d  = m_read_paddr;

    case (state_q)
      IDLE: begin
        if (arb_en && arb_any) begin
          grant_d         = arb_grant;
          write_d         = req_write[arb_grant];
          req_ready_d     = ONE_HOT0 << arb_grant;
          m_transfer_d    = 1'b1;
          m_read_write_d  = req_write[arb_grant] ? RW_WRITE : RW_READ;
          m_write_paddr_d = '0;
          m_write_data_d  = '0;
          m_read_paddr_d  = '0;
          if (req_write[arb_grant]) begin
            m_write_paddr_d = req_addr[int'(arb_grant)*AW +: AW];
            m_write_data_d  = req_wdata[int'(arb_grant)*DW +: DW];
          end else begin
            m_read_paddr_d  = req_addr[int'(arb_grant)*AW +: AW];
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion is tested first so it wins over a timeout in the same cycle
        if ((m_penable && m_pready) || ((TIMEOUT != 0) && (timer_q == TIMER_LAST))) begin
          rsp_valid_d     = ONE_HOT0 << grant_q;
          rsp_err_d       = !(m_penable && m_pready);
          rsp_rdata_d     = (m_penable && m_pready && !write_q) ? m_read_data : '0;
          last_grant_d    = grant_q;
          m_transfer_d    = 1'b0;
          m_read_write_d  = 1'b0;
          m_write_paddr_d = '0;
          m_write_data_d  = '0;
          m_read_paddr_d  = '0;
          state_d         = RESP;
        end else if (timer_q != {TW{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, latched request and registered outputs; reset drops any in-flight request
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= GW'(NUM_REQ - 1);
      write_q       <= 1'b0;
      timer_q       <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      busy          <= 1'b0;
      m_transfer    <= 1'b0;
      m_read_write  <= 1'b0;
      m_write_paddr <= '0;
      m_write_data  <= '0;
      m_read_paddr  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      write_q       <= write_d;
      timer_q       <= timer_d;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_err       <= rsp_err_d;
      busy          <= busy_d;
      m_transfer    <= m_transfer_d;
      m_read_write  <= m_read_write_d;
      m_write_paddr <= m_write_paddr_d;
      m_write_data  <= m_write_data_d;
      m_read_paddr  <= m_read_paddr_d;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed testbench for apb_req_arbiter with a small behavioural APB slave
// whose wait states, stuck-PREADY mode and read data are set per transfer.
module tb_apb_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic                  PCLK = 1'b0;
  logic                  PRESETn = 1'b0;
  logic                  arb_en = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_write = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*DW-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err, busy, m_transfer, m_read_write;
  logic [AW-1:0]         m_write_paddr, m_read_paddr;
  logic [DW-1:0]         m_write_data;
  logic                  m_penable = 1'b0;
  logic                  m_pready = 1'b0;
  logic [DW-1:0]         m_read_data = '0;

  int         num_checks = 0;
  int         num_fails  = 0;
  int         slave_wait = 0;
  int         slave_cnt  = 0;
  logic       slave_stuck = 1'b0;
  logic [7:0] slave_rdata = 8'h00;

  apb_req_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .arb_en        (arb_en),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .m_transfer    (m_transfer),
    .m_read_write  (m_read_write),
    .m_write_paddr (m_write_paddr),
    .m_write_data  (m_write_data),
    .m_read_paddr  (m_read_paddr),
    .m_penable     (m_penable),
    .m_pready      (m_pready),
    .m_read_data   (m_read_data)
  );

  always #5 PCLK = ~PCLK;

  // Slave: PENABLE one cycle after transfer rises, PREADY after slave_wait WAIT cycles
  always @(negedge PCLK) begin
    m_read_data = slave_rdata;
    if (m_transfer) begin
      slave_cnt = slave_cnt + 1;
      m_penable = 1'b1;
      m_pready  = !slave_stuck && (slave_cnt > slave_wait + 1);
    end else begin
      slave_cnt = 0;
      m_penable = 1'b0;
      m_pready  = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge PCLK);
      n++;
    end
  endtask

  task automatic wait_rsp(output int xfer_cycles);
    int n = 0;
    xfer_cycles = 0;
    while (rsp_valid == '0 && n < 100) begin
      if (m_transfer) xfer_cycles++;
      @(negedge PCLK);
      n++;
    end
  endtask

  // One complete request from requester idx, checked end to end
  task automatic applyStimulus(input int idx, input logic wr, input logic [7:0] addr,
                               input logic [7:0] wdata, input int wait_cyc, input logic stuck,
                               input logic [7:0] srdata, input logic [7:0] exp_rdata,
                               input logic exp_err, input int exp_xfer);
    int xfer;
    logic [NUM_REQ-1:0] exp_hot;
    exp_hot     = NUM_REQ'(1) << idx;
    slave_wait  = wait_cyc;
    slave_stuck = stuck;
    slave_rdata = srdata;
    req_write[idx]           = wr;
    req_addr[idx*AW +: AW]   = addr;
    req_wdata[idx*DW +: DW]  = wdata;
    req_valid[idx]           = 1'b1;
    wait_ready();
    checkOutput($sformatf("req_ready_%0d", idx), 32'(req_ready), 32'(exp_hot));
    req_valid[idx] = 1'b0;
    checkOutput("m_transfer_issue", 32'(m_transfer), 32'd1);
    checkOutput("busy_issue", 32'(busy), 32'd1);
    checkOutput("m_read_write", 32'(m_read_write), 32'(!wr));
    checkOutput("m_write_paddr", 32'(m_write_paddr), wr ? 32'(addr) : 32'd0);
    checkOutput("m_write_data", 32'(m_write_data), wr ? 32'(wdata) : 32'd0);
    checkOutput("m_read_paddr", 32'(m_read_paddr), wr ? 32'd0 : 32'(addr));
    wait_rsp(xfer);
    checkOutput($sformatf("rsp_valid_%0d", idx), 32'(rsp_valid), 32'(exp_hot));
    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    checkOutput("transfer_cycles", 32'(xfer), 32'(exp_xfer));
    checkOutput("m_transfer_resp", 32'(m_transfer), 32'd0);
    @(negedge PCLK);
    checkOutput("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    checkOutput("rsp_rdata_hold", 32'(rsp_rdata), 32'(exp_rdata));
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic saw;
    int   xfer;
    logic [NUM_REQ-1:0] exp_hot;

    $display("[TB] apb_req_arbiter directed test");
    repeat (3) @(negedge PCLK);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_m_transfer", 32'(m_transfer), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    PRESETn = 1'b1;
    arb_en  = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      if (m_transfer || busy || req_ready != '0) saw = 1'b1;
    end
    checkOutput("idle_no_activity", 32'(saw), 32'd0);

    // Round robin: all four held for eight transfers
    req_write   = '1;
    req_addr    = {8'h43, 8'h42, 8'h41, 8'h40};
    req_wdata   = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    slave_wait  = 0;
    slave_stuck = 1'b0;
    req_valid   = '1;
    for (int t = 0; t < 8; t++) begin
      exp_hot = NUM_REQ'(1) << (t % NUM_REQ);
      wait_ready();
      checkOutput($sformatf("rr_grant_%0d", t), 32'(req_ready), 32'(exp_hot));
      checkOutput($sformatf("rr_paddr_%0d", t), 32'(m_write_paddr), 32'h40 + 32'(t % NUM_REQ));
      if (t == 7) req_valid = '0;
      wait_rsp(xfer);
      checkOutput($sformatf("rr_rsp_%0d", t), 32'(rsp_valid), 32'(exp_hot));
    end
    @(negedge PCLK);

    // Write from requester 0, zero-wait slave; slave data must not leak into write response
    applyStimulus(0, 1'b1, 8'h12, 8'hA5, 0, 1'b0, 8'hEE, 8'h00, 1'b0, 2);
    // Read from requester 2 with three wait states
    applyStimulus(2, 1'b0, 8'h34, 8'h00, 3, 1'b0, 8'h5C, 8'h5C, 1'b0, 5);
    // Stuck slave: timeout after 16 WAIT cycles
    applyStimulus(1, 1'b0, 8'h77, 8'h00, 0, 1'b1, 8'hAB, 8'h00, 1'b1, 17);
    // Next request served normally after a timeout
    applyStimulus(3, 1'b0, 8'h56, 8'h00, 0, 1'b0, 8'h3C, 8'h3C, 1'b0, 2);
    // Completion in the same cycle as timeout expiry wins
    applyStimulus(0, 1'b0, 8'h9A, 8'h00, 15, 1'b0, 8'h99, 8'h99, 1'b0, 17);

    // arb_en low blocks new grants
    arb_en = 1'b0;
    req_valid[1] = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge PCLK);
      if (req_ready != '0 || busy) saw = 1'b1;
    end
    checkOutput("arb_en_blocks", 32'(saw), 32'd0);
    req_valid[1] = 1'b0;
    arb_en = 1'b1;
    applyStimulus(1, 1'b1, 8'h21, 8'h5A, 0, 1'b0, 8'h00, 8'h00, 1'b0, 2);
    checkOutput("rdata_after_write", 32'(rsp_rdata), 32'd0);
    applyStimulus(2, 1'b0, 8'h66, 8'h00, 0, 1'b0, 8'h81, 8'h81, 1'b0, 2);

    // Reset in WAIT: outputs drop at once, request dropped, requester 0 first afterwards
    slave_stuck = 1'b1;
    req_write[2] = 1'b0;
    req_valid[2] = 1'b1;
    wait_ready();
    req_valid[2] = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    checkOutput("rst_m_transfer", 32'(m_transfer), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    slave_stuck = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      if (rsp_valid != '0 || m_transfer) saw = 1'b1;
    end
    checkOutput("rst_no_response", 32'(saw), 32'd0);
    req_write = '1;
    req_valid = '1;
    wait_ready();
    req_valid = '0;
    checkOutput("rst_first_grant", 32'(req_ready), 32'd1);
    wait_rsp(xfer);
    checkOutput("rst_first_rsp", 32'(rsp_valid), 32'd1);
    repeat (3) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
